// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
package seg_scan_pkg;

  localparam logic [31:0] ADDR_B0 = 32'h0000_00B0;
  localparam logic [31:0] ADDR_B4 = 32'h0000_00B4;
  localparam logic [31:0] ADDR_B8 = 32'h0000_00B8;
  localparam logic [31:0] ADDR_BC = 32'h0000_00BC;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [5:0] DIG_OFF   = 6'h3F;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_seg.sv
// Hex nibble to active-low 7-segment code, bit 0 = segment a.
module seven_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; segments are driven low to light.
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0:    seg = ~7'h3F;
      4'h1:    seg = ~7'h06;
      4'h2:    seg = ~7'h5B;
      4'h3:    seg = ~7'h4F;
      4'h4:    seg = ~7'h66;
      4'h5:    seg = ~7'h6D;
      4'h6:    seg = ~7'h7D;
      4'h7:    seg = ~7'h07;
      4'h8:    seg = ~7'h7F;
      4'h9:    seg = ~7'h6F;
      4'hA:    seg = ~7'h77;
      4'hB:    seg = ~7'h7C;
      4'hC:    seg = ~7'h39;
      4'hD:    seg = ~7'h5E;
      4'hE:    seg = ~7'h79;
      4'hF:    seg = ~7'h71;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_control.sv
// Six-digit multiplexed 7-segment scan controller with a bus-written
// digit store. Optional brightness duty control under SEG_SCAN_BRIGHT_EN.
module seg_scan_control
  import seg_scan_pkg::*;
#(
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        output_write,
  output logic [6:0]  seg_out,
  output logic [5:0]  digit_en
);

  localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  // At least 3 bits so the duty comparison always has counter[2:0].
  localparam int CW = ($clog2(MAX_CYC) < 3) ? 3 : $clog2(MAX_CYC);

  scan_state_t                 state_r;
  logic [CW-1:0]               cnt_r;
  logic [2:0]                  idx_r;
  logic [NUM_DIGITS-1:0]       valid_r;
  logic [NUM_DIGITS-1:0][3:0]  nib_r;
  logic                        sel_valid_s;
  logic [3:0]                  sel_nib_s;
  logic [6:0]                  seg_code_s;
  logic                        show_en_s;
  logic                        unused_s;

`ifdef SEG_SCAN_BRIGHT_EN
  logic [2:0]                  duty_r;
`endif

  assign unused_s = ^data_in[31:8];

  // Digit store: bus writes load nibble pairs, unmapped addresses blank all.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_r <= {NUM_DIGITS{1'b0}};
      nib_r   <= '0;
`ifdef SEG_SCAN_BRIGHT_EN
      duty_r  <= 3'd7;
`endif
    end else if (output_write) begin
      case (addr)
        ADDR_B0: begin
          nib_r[0]     <= data_in[3:0];
          nib_r[1]     <= data_in[7:4];
          valid_r[1:0] <= 2'b11;
        end
        ADDR_B4: begin
          nib_r[2]     <= data_in[3:0];
          nib_r[3]     <= data_in[7:4];
          valid_r[3:2] <= 2'b11;
        end
        ADDR_B8: begin
          nib_r[4]     <= data_in[3:0];
          nib_r[5]     <= data_in[7:4];
          valid_r[5:4] <= 2'b11;
        end
`ifdef SEG_SCAN_BRIGHT_EN
        ADDR_BC: begin
          duty_r <= data_in[2:0];
        end
`endif
        default: begin
          valid_r <= {NUM_DIGITS{1'b0}};
        end
      endcase
    end
  end

  // Scan FSM: SHOW for SHOW_CYC cycles, BLANK for BLANK_CYC, then next digit.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= ST_SHOW;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
    end else begin
      case (state_r)
        ST_SHOW: begin
          if (cnt_r == CW'(SHOW_CYC - 1)) begin
            state_r <= ST_BLANK;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_BLANK: begin
          if (cnt_r == CW'(BLANK_CYC - 1)) begin
            state_r <= ST_SHOW;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= (idx_r == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_r + 3'd1;
          end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_SHOW;
          cnt_r   <= {CW{1'b0}};
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

  // Select the slot addressed by the scan index.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_nib_s   = 4'h0;
    case (idx_r)
      3'd0:    begin sel_valid_s = valid_r[0]; sel_nib_s = nib_r[0]; end
      3'd1:    begin sel_valid_s = valid_r[1]; sel_nib_s = nib_r[1]; end
      3'd2:    begin sel_valid_s = valid_r[2]; sel_nib_s = nib_r[2]; end
      3'd3:    begin sel_valid_s = valid_r[3]; sel_nib_s = nib_r[3]; end
      3'd4:    begin sel_valid_s = valid_r[4]; sel_nib_s = nib_r[4]; end
      3'd5:    begin sel_valid_s = valid_r[5]; sel_nib_s = nib_r[5]; end
      default: begin sel_valid_s = 1'b0;       sel_nib_s = 4'h0;     end
    endcase
  end

  // Digit drive gating: continuous, or limited to the duty window.
  always_comb begin
`ifdef SEG_SCAN_BRIGHT_EN
    if (cnt_r[2:0] <= duty_r) begin
      show_en_s = 1'b1;
    end else begin
      show_en_s = 1'b0;
    end
`else
    show_en_s = 1'b1;
`endif
  end

  seven_seg u_seven_seg (
    .nibble (sel_nib_s),
    .seg    (seg_code_s)
  );

  // Registered display outputs, one cycle behind the scan/slot state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_out  <= SEG_BLANK;
      digit_en <= DIG_OFF;
    end else if ((state_r == ST_SHOW) && sel_valid_s) begin
      seg_out  <= seg_code_s;
      digit_en <= show_en_s ? ~(6'b00_0001 << idx_r) : DIG_OFF;
    end else begin
      seg_out  <= SEG_BLANK;
      digit_en <= DIG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_control.sv
// Self-checking bench for seg_scan_control (SHOW_CYC=4, BLANK_CYC=2).
// The reference model derives the scan position from the cycle count since
// reset and keeps its own copy of the digit store.
module tb_seg_scan_control;

  localparam int S     = 4;
  localparam int B     = 2;
  localparam int SLOT  = S + B;
  localparam int PER   = 6 * SLOT;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        output_write;
  logic [6:0]  seg_out;
  logic [5:0]  digit_en;

  int total = 0;
  int bad   = 0;

  // model state
  int         k;
  bit [5:0]   m_valid;
  logic [3:0] m_nib [6];
  int         m_duty;
  logic [6:0] exp_seg;
  logic [5:0] exp_en;

  seg_scan_control #(.SHOW_CYC(S), .BLANK_CYC(B)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .addr         (addr),
    .data_in      (data_in),
    .output_write (output_write),
    .seg_out      (seg_out),
    .digit_en     (digit_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, got, want);
    end
  endtask

  function automatic logic [6:0] hex_code(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  function automatic int cur_digit(input int kk);
    return (kk % PER) / SLOT;
  endfunction

  function automatic int cur_within(input int kk);
    return kk % SLOT;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int p;
    p = -1;
    if (a == 32'hB0) p = 0;
    else if (a == 32'hB4) p = 2;
    else if (a == 32'hB8) p = 4;
`ifdef SEG_SCAN_BRIGHT_EN
    if (a == 32'hBC) begin
      m_duty = int'(d[2:0]);
      return;
    end
`endif
    if (p < 0) begin
      m_valid = '0;
    end else begin
      m_nib[p]     = d[3:0];
      m_nib[p+1]   = d[7:4];
      m_valid[p]   = 1'b1;
      m_valid[p+1] = 1'b1;
    end
  endtask

  // One clock: update the model at the edge, compare outputs 1 time unit later.
  task automatic tick();
    int d;
    int w;
    @(posedge clock);
    if (!resetn) begin
      k = 0;
      exp_seg = 7'h7F;
      exp_en  = 6'h3F;
      m_valid = '0;
      for (int i = 0; i < 6; i++) m_nib[i] = 4'h0;
      m_duty = 7;
    end else begin
      d = cur_digit(k);
      w = cur_within(k);
      if (w < S && m_valid[d]) begin
        exp_seg = hex_code(m_nib[d]);
        exp_en  = ((w % 8) <= m_duty) ? ~(6'(1) << d) : 6'h3F;
      end else begin
        exp_seg = 7'h7F;
        exp_en  = 6'h3F;
      end
      k++;
      if (output_write) model_write(addr, data_in);
    end
    #1;
    check_val("seg_out", {25'd0, seg_out}, {25'd0, exp_seg});
    check_val("digit_en", {26'd0, digit_en}, {26'd0, exp_en});
    check_val("one_low", ($countones(~digit_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    data_in = d;
    output_write = 1'b1;
    tick();
    output_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model's scan position reaches (digit, within); bounded.
  task automatic wait_phase(input int dg, input int wi);
    int n;
    n = 0;
    while (!(cur_digit(k) == dg && cur_within(k) == wi) && n < 2 * PER) begin
      tick();
      n++;
    end
    check_val("wait_phase", (n < 2 * PER) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    resetn = 1'b0;
    addr = 32'h0;
    data_in = 32'h0;
    output_write = 1'b0;
    k = 0;
    m_valid = '0;
    m_duty = 7;
    for (int i = 0; i < 6; i++) m_nib[i] = 4'h0;

    // reset with a coincident write that must be ignored
    tick();
    addr = 32'hB0; data_in = 32'h21; output_write = 1'b1;
    tick();
    output_write = 1'b0;
    tick();
    resetn = 1'b1;

    // idle: everything dark
    idle(40);

    // two digits, across more than one scan period
    bus_write(32'hB0, 32'h21);
    idle(2 * PER);

    // fill all, then clear with an unmapped address
    bus_write(32'hB0, 32'h10);
    bus_write(32'hB4, 32'h32);
    bus_write(32'hB8, 32'h54);
    idle(PER);
    bus_write(32'hC0, 32'h0);
    idle(PER);

    // rewrite the slot currently being shown
    bus_write(32'hB4, 32'h76);
    wait_phase(3, 1);
    bus_write(32'hB4, 32'hA0);
    idle(SLOT + 2);

    // 0xBC: duty register with the option, otherwise a clearing write
    bus_write(32'hB0, 32'h98);
    bus_write(32'hBC, 32'h1);
    idle(PER);

    // reset mid-BLANK of slot 4
    bus_write(32'hB8, 32'hFE);
    bus_write(32'hB0, 32'hDC);
    wait_phase(4, S);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus_write(32'hB0, 32'h43);
    idle(PER);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        case ($urandom_range(0, 5))
          0: ra = 32'hB0;
          1: ra = 32'hB4;
          2: ra = 32'hB8;
          3: ra = 32'hBC;
          4: ra = 32'hC0;
          default: ra = $urandom;
        endcase
        addr = ra;
        data_in = $urandom;
        output_write = 1'b1;
      end else if (r == 99) begin
        resetn = 1'b0;
      end
      tick();
      output_write = 1'b0;
      resetn = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_control.md
SEG_SCAN_CONTROL -- requirements
Module: seg_scan_control

Interface
REQ-001 Parameter SHOW_CYC, default 1000: clock cycles each digit is driven per scan slot; minimum 1.
REQ-002 Parameter BLANK_CYC, default 4: inter-digit blanking cycles (anti-ghosting); minimum 1.
REQ-003 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: reset, synchronous and active-low.
REQ-005 Port addr, input, 32: bus write address.
REQ-006 Port data_in, input, 32: bus write data.
REQ-007 Port output_write, input, 1: bus write strobe, sampled on the rising edge of clock.
REQ-008 Port seg_out, output, 7: shared segment bus, active-low, bit 0 = segment a.
REQ-009 Port digit_en, output, 6: digit enables, active-low, at most one bit low at any time.

Function
REQ-010 Six 5-bit digit slots SHALL exist: a valid bit plus a 4-bit nibble.
REQ-011 A write with output_write=1 to addr 0x000000B0 SHALL load data_in[3:0] into slot 0 and data_in[7:4] into slot 1, setting both valid bits.
REQ-012 Writes to 0xB4 and 0xB8 SHALL load slots 2/3 and 4/5 respectively, using the same nibble mapping.
REQ-013 A write to any other address, except 0xBC when SEG_SCAN_BRIGHT_EN is defined, SHALL clear all six valid bits.
REQ-014 The scan FSM SHALL have two states: SHOW and BLANK.
  - SHOW: lasts SHOW_CYC cycles, then the FSM goes to BLANK.
  - BLANK: lasts BLANK_CYC cycles, then the digit index advances and the FSM returns to SHOW.
REQ-015 The digit index SHALL advance 0,1,...,5 and then wrap to 0; the cycle counter SHALL reset to 0 on every state change.
REQ-016 In SHOW, digit_en SHALL have only bit[index] low if slot[index] is valid; if the slot is invalid, digit_en SHALL be 6'h3F.
REQ-017 In SHOW, seg_out SHALL carry the active-low 7-segment code of the slot nibble (hex 0-F); in BLANK, or for an invalid slot, seg_out SHALL be 7'h7F.
REQ-018 seg_out and digit_en SHALL be registered, with exactly one cycle of latency from the FSM/slot state to the outputs.
REQ-019 If a write hits the slot currently shown, the new code SHALL appear on seg_out at the edge after the write edge, with no scan disturbance.
REQ-020 Writes SHALL NOT alter the FSM state, the counter or the digit index.

Reset
REQ-021 With resetn=0 at a rising edge, the following SHALL take effect on that edge, regardless of the current state:
  - seg_out = 7'h7F and digit_en = 6'h3F;
  - all valid bits = 0 and nibbles = 0;
  - state = SHOW, index = 0, counter = 0.
REQ-022 A write coincident with reset SHALL be ignored.
REQ-023 The first SHOW slot after reset release SHALL begin on the first edge with resetn=1.

Configuration
REQ-024 With macro SEG_SCAN_BRIGHT_EN defined:
  - a 3-bit duty register SHALL exist, reset to 7, loaded from data_in[2:0] on a write to 0xBC (the write does not clear any slots);
  - in SHOW, digit_en SHALL be low only while counter[2:0] <= duty, otherwise 6'h3F, with seg_out unchanged.
REQ-025 Without SEG_SCAN_BRIGHT_EN: no duty register; 0xBC SHALL be treated as an unmapped address per REQ-013; SHOW drive SHALL be continuous.

Structure
REQ-026 Shared package seg_scan_pkg SHALL hold:
  - address constants 0xB0/0xB4/0xB8/0xBC;
  - NUM_DIGITS=6;
  - the SHOW/BLANK state typedef;
  - the blank constants 7'h7F and 6'h3F.
REQ-027 Hex-to-segment decode SHALL be the existing sub-module seven_seg, instantiated once on the selected nibble; all other logic SHALL be in seg_scan_control.

Verification (bench parameters SHOW_CYC=4, BLANK_CYC=2)
REQ-028 Reset, then no writes for 40 cycles -> seg_out=7'h7F and digit_en=6'h3F throughout.
REQ-029 Write 0xB0 data 0x21 -> slot 0 shows code("1") with digit_en=6'h3E for 4 cycles; then 2 blank cycles; then slot 1 shows code("2") with digit_en=6'h3D; slots 2-5 dark; the 6-digit scan period is 36 cycles.
REQ-030 Fill 0xB0/B4/B8 with 0x10/0x32/0x54, then write to 0xC0 -> within one cycle, all digits dark; the scan index keeps advancing.
REQ-031 While slot 3 is displayed, write 0xB4 data 0xA0 -> seg_out changes to code("A") on the next edge; the slot's timing is unchanged.
REQ-032 Assert resetn=0 for one cycle mid-BLANK of slot 4 -> outputs blank on that edge; the scan restarts at slot 0 with the full SHOW_CYC.
REQ-033 With SEG_SCAN_BRIGHT_EN, write 0xBC data 1 and SHOW_CYC=8 -> digit_en is low on counter values 0,1 and high on 2-7; without the macro, the same write clears all slots.
